// File: rtl/rpn_pkg.sv
// Shared types for the RPN program sequencer: instruction layout, opcodes, FSM states.
// No logic of its own; the helpers are pure combinational functions.
// Imported by prog_mem and rpn_sequencer.
package rpn_pkg;

    // Instruction kind field, bits [17:16] of a program word.
    typedef enum logic [1:0] {
        K_PUSH = 2'b00,
        K_OP   = 2'b01,
        K_HALT = 2'b10,
        K_NOP  = 2'b11
    } kind_e;

    // Arithmetic unit opcodes carried in imm[2:0] of an OP word.
    localparam logic [2:0] OP_NZ   = 3'd0;
    localparam logic [2:0] OP_NEG  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_SWAP = 3'd4;
    localparam logic [2:0] OP_LOAD = 3'd5;
    localparam logic [2:0] OP_POP6 = 3'd6;
    localparam logic [2:0] OP_POP7 = 3'd7;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Capacity of the downstream stack.
    localparam int unsigned STACK_MAX = 1000;

    // 18-bit program word.
    typedef struct packed {
        kind_e       kind;
        logic [15:0] imm;
    } instr_t;

    // Swap and load need one extra cycle in the arithmetic unit.
    function automatic logic op_is_long(input logic [2:0] op);
        return (op == OP_SWAP) || (op == OP_LOAD);
    endfunction

    // Stack depth requirement of an instruction; HALT/NOP always pass.
    function automatic logic depth_ok(input instr_t ins, input logic [9:0] cnt,
                                      input logic [31:0] tos);
        logic ok;
        ok = 1'b1;
        case (ins.kind)
            K_PUSH: ok = (cnt < 10'(STACK_MAX));
            K_OP: begin
                case (ins.imm[2:0])
                    OP_NZ, OP_NEG, OP_POP6, OP_POP7: ok = (cnt >= 10'd1);
                    OP_ADD, OP_MUL, OP_SWAP:         ok = (cnt >= 10'd2);
                    default:                         ok = (32'(cnt) > tos);
                endcase
            end
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rpn_sequencer_prog_mem.sv
// Program store: 2^AW x 18-bit words, synchronous write, asynchronous read.
// Latency: write lands on the clock edge; read is combinational from addr.
// No backpressure; contents are never reset.
//
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module prog_mem #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [17:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [17:0]   rdata
);

    logic [17:0] mem [0:(1<<AW)-1];

    // Program survives reset on purpose, so there is no reset branch here.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rpn_sequencer.sv
// Replays a stored RPN program into the stack arithmetic unit and returns its top of stack.
// Latency: issues one instruction per 2 cycles (3 for swap/load, 1 for NOP); done one cycle after HALT.
// No backpressure: issue spacing is fixed to the unit's latency; start/prog_we are ignored while busy.
//
// Ports: clk/rst (async active-high); start; prog_we/prog_addr/prog_data program write port;
//        au_push/au_en/au_d/au_op drive the unit, au_out/au_cnt read it back;
//        busy/done/err/result/pc status.
// Build option: define RPN_SEQ_DEPTH_CHECK_EN to abort with err on stack depth violations.
module rpn_sequencer
    import rpn_pkg::*;
#(
    parameter int PROG_AW = 8,
    parameter int DATA_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               prog_we,
    input  logic [PROG_AW-1:0] prog_addr,
    input  logic [17:0]        prog_data,
    output logic               au_push,
    output logic               au_en,
    output logic [DATA_W-1:0]  au_d,
    output logic [2:0]         au_op,
    input  logic [DATA_W-1:0]  au_out,
    input  logic [9:0]         au_cnt,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [DATA_W-1:0]  result,
    output logic [PROG_AW-1:0] pc
);

    localparam logic [PROG_AW-1:0] PC_LAST = '1;

    state_e              state_q, state_d;
    logic [PROG_AW-1:0]  pc_q, pc_d;
    logic                wcnt_q, wcnt_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                err_q, err_d;

    logic [17:0]         rd_data;
    instr_t              ins;
    logic                mem_we;
    logic                chk_ok;

    assign busy   = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done   = (state_q == S_DONE);
    assign err    = err_q;
    assign result = result_q;
    assign pc     = pc_q;

    // Program writes must not disturb a running program.
    assign mem_we = prog_we && !busy;

    prog_mem #(
        .AW (PROG_AW)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_q),
        .rdata (rd_data)
    );

    assign ins = instr_t'(rd_data);

`ifdef RPN_SEQ_DEPTH_CHECK_EN
    assign chk_ok = depth_ok(ins, au_cnt, 32'(au_out));
`else
    // Without the check every word is issued; the unit drops invalid ops itself.
    logic unused_au_cnt;
    assign unused_au_cnt = ^au_cnt;
    assign chk_ok        = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        wcnt_d   = wcnt_q;
        result_d = result_q;
        err_d    = err_q;
        au_en    = 1'b0;
        au_push  = 1'b0;
        au_d     = '0;
        au_op    = 3'd0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pc_d    = '0;
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                case (ins.kind)
                    K_HALT: begin
                        result_d = au_out;
                        state_d  = S_DONE;
                    end
                    K_NOP: begin
                        pc_d = pc_q + 1'b1;
                    end
                    default: begin
                        if (!chk_ok) begin
                            err_d    = 1'b1;
                            result_d = au_out;
                            state_d  = S_DONE;
                        end else begin
                            au_en   = 1'b1;
                            pc_d    = pc_q + 1'b1;
                            state_d = S_WAIT;
                            if (ins.kind == K_PUSH) begin
                                au_push = 1'b1;
                                au_d    = DATA_W'(ins.imm);
                                wcnt_d  = 1'b0;
                            end else begin
                                au_op  = ins.imm[2:0];
                                wcnt_d = op_is_long(ins.imm[2:0]);
                            end
                        end
                    end
                endcase

                // Ran off the end of program memory without a HALT. The last word
                // still issues, but pc is held rather than wrapped to 0.
                if ((ins.kind != K_HALT) && (pc_q == PC_LAST)) begin
                    err_d    = 1'b1;
                    result_d = au_out;
                    pc_d     = pc_q;
                    state_d  = S_DONE;
                end
            end

            S_WAIT: begin
                if (!wcnt_q) begin
                    state_d = S_ISSUE;
                end else begin
                    wcnt_d = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            wcnt_q   <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            wcnt_q   <= wcnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: doc/rpn_sequencer.md
# rpn_sequencer

Program sequencer that sits directly upstream of the stack arithmetic unit. It holds a small RPN program (push/op/halt words) loaded through a write port. On `start` it replays the program into the unit's `push`/`en`/`d`/`op` inputs, spacing each issue to match the unit's per-operation latency. When it reaches a halt it returns the top-of-stack value and signals completion.

## Interface
- `PROG_AW`, 8: program address width; memory depth is 2^PROG_AW words.
- `DATA_W`, 16: data width; equals the arithmetic unit's data width.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin execution at address 0; honoured only in IDLE or DONE.
- `prog_we`  in  1  program write strobe; ignored while `busy`.
- `prog_addr`  in  PROG_AW  program write address.
- `prog_data`  in  18  instruction word: [17:16] kind (00 PUSH, 01 OP, 10 HALT, 11 NOP); [15:0] immediate for PUSH; [2:0] opcode for OP.
- `au_push`  out  1  to arithmetic unit `push`.
- `au_en`  out  1  to arithmetic unit `en`; single-cycle pulse per issued instruction.
- `au_d`  out  DATA_W  to arithmetic unit `d`.
- `au_op`  out  3  to arithmetic unit `op`.
- `au_out`  in  DATA_W  arithmetic unit top of stack.
- `au_cnt`  in  10  arithmetic unit stack depth.
- `busy`  out  1  high in ISSUE and WAIT.
- `done`  out  1  high in DONE; held until the next `start` or reset.
- `err`  out  1  abnormal termination flag; valid while `done`.
- `result`  out  DATA_W  `au_out` captured at HALT.
- `pc`  out  PROG_AW  current program address.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE/DONE with `start`=1:
  - `pc`←0, clear `err`, go to ISSUE.
  - `done` drops on the same edge.
- ISSUE: decode the word at `pc`. Program memory read is combinational.
  - PUSH: `au_en`=1, `au_push`=1, `au_d`=imm. Then `pc`+1 and WAIT with `wcnt`←0.
  - OP with opcode 4 (swap) or 5 (load): `au_en`=1, `au_op`=opcode, `au_push`=0. Then `pc`+1 and WAIT with `wcnt`←1.
  - Other OP: same issue, then `pc`+1 and WAIT with `wcnt`←0.
  - NOP: no issue; `pc`+1, stay in ISSUE.
  - HALT: no issue; `result`←`au_out`, go to DONE.
- WAIT: if `wcnt`=0, go to ISSUE; otherwise decrement `wcnt`.
- `pc` overflow: if `pc`=2^PROG_AW−1 is consumed without HALT, set `err`=1, capture `result`, go to DONE.
- Inactive outputs: when not issuing, `au_en`=0, `au_push`=0, and `au_d`/`au_op` are driven 0.
- Program writes take effect on the clock edge. Writes while `busy` are dropped. Writes in DONE are allowed.
- `start` while `busy` is ignored.
- Reset (asynchronous, any state, including mid-program):
  - State→IDLE; `pc`, `result`, `done`, `err`, `busy`, `au_*` outputs all 0.
  - Program memory contents are retained.

## Timing
- `start` is sampled at edge 0. The first instruction issues in the cycle after edge 0.
- Issue spacing, issue to next issue:
  - PUSH and opcodes 0–3, 6, 7: 2 cycles.
  - Opcodes 4–5: 3 cycles.
  - NOP: 1 cycle.
- `au_out` is stable in every ISSUE cycle, so the HALT capture is exact.
- `done` rises one cycle after the HALT ISSUE cycle.
- Latency for N non-NOP instructions plus HALT: 2·N + (count of ops 4/5) + 1 cycles from the start edge to `done`.

## Configuration
- Macro: `RPN_SEQ_DEPTH_CHECK_EN`.
- Defined: in ISSUE, before issuing, the sequencer checks the stack depth against each instruction's requirement.
  - Requirements:
    - PUSH needs `au_cnt`<1000.
    - Opcodes 0, 1, 6, 7 need `au_cnt`≥1.
    - Opcodes 2, 3, 4 need `au_cnt`≥2.
    - Opcode 5 needs `au_cnt`>`au_out`.
  - On violation: no `au_en` pulse, `err`←1, `result`←`au_out`, go to DONE.
- Undefined: no check. Every word is issued; the arithmetic unit silently ignores invalid ops. `err` is set only by `pc` overflow.

## Structure
- Package `rpn_pkg`:
  - Kind enum: PUSH, OP, HALT, NOP.
  - Opcode constants: OP_NZ=0, OP_NEG=1, OP_ADD=2, OP_MUL=3, OP_SWAP=4, OP_LOAD=5, OP_POP6=6, OP_POP7=7.
  - State enum.
  - `STACK_MAX`=1000.
  - Instruction struct: 18 bits.
- Sub-module `prog_mem`: 2^PROG_AW×18 memory, synchronous write, asynchronous read.

## Test plan
- Add: program PUSH 3, PUSH 4, OP 2, HALT; `start` → `done`=1 at cycle 8 with `result`=7, `err`=0, `au_en` pulses in cycles 1, 3, 5.
- Swap: program PUSH 5, PUSH 9, OP 4, HALT → `au_en` in cycles 1, 3, 5; `done` at cycle 9; `result`=5.
- Overflow: program all NOP → `done` after 256 ISSUE cycles, `err`=1, no `au_en` pulse.
- Depth check: with `RPN_SEQ_DEPTH_CHECK_EN`, program OP 2, HALT on an empty stack → `err`=1, `done` at cycle 2, no `au_en`. Without the macro, `au_en` pulses once and `err`=0.
- Reset mid-run: assert `rst` in cycle 4 of the add program → all outputs 0 immediately. After release, `start` reruns the retained program to `result`=7.
- Ignored inputs: `start` and `prog_we` during `busy` → no restart, memory unchanged, `pc` sequence unaffected.
